// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback slice: opcode set, default
// sizes and the instruction record used by producers of alu_dispatch traffic.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 8;
    localparam int OP_W_DEF   = 4;
    localparam int RW_DEF     = $clog2(NREGS_DEF);

    typedef enum logic [OP_W_DEF-1:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef struct packed {
        alu_op_e               op;
        logic [RW_DEF-1:0]     rd;
        logic [RW_DEF-1:0]     rs1;
        logic [RW_DEF-1:0]     rs2;
        logic                  imm_en;
        logic [DATA_W_DEF-1:0] imm;
    } alu_instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, r0 reads as zero and ignores writes. No internal bypass.
module alu_regfile
    import alu_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [RW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [RW-1:0]     wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: this array is a handful of flops, so resetting it is cheap; a real
    // SRAM macro could not be cleared this way and would need an init sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_dispatch.sv
// Issue/writeback stage around a combinational ALU: E register feeds the ALU,
// W register holds the result until the downstream handshake retires it.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int OP_W   = OP_W_DEF,
    localparam int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [RW-1:0]     in_rd,
    input  logic [RW-1:0]     in_rs1,
    input  logic [RW-1:0]     in_rs2,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RW-1:0]     res_rd,
    output logic [DATA_W-1:0] res_data
);

    logic              e_valid;
    logic [RW-1:0]     e_rd;
    logic              w_valid;
    logic              w_adv;
    logic              e_adv;
    logic              retire;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] opnd_b;

    assign w_adv     = !w_valid || res_ready;
    assign e_adv     = !e_valid || w_adv;
    assign in_ready  = e_adv;
    assign res_valid = w_valid;
    assign retire    = w_valid && res_ready;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (in_rs1),
        .ra_data (rf_a),
        .rb_addr (in_rs2),
        .rb_data (rf_b),
        .we      (retire),
        .wa      (res_rd),
        .wd      (res_data)
    );

    // Youngest producer wins: E (result still on alu_y) before W before the
    // file. A W entry retiring this cycle is not yet in the file, hence W.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        src_a = rf_a;
        if (in_rs1 == '0) begin
            src_a = '0;
        end else if (e_valid && e_rd == in_rs1) begin
            src_a = alu_y;
        end else if (w_valid && res_rd == in_rs1) begin
            src_a = res_data;
        end

        src_b = rf_b;
        if (in_rs2 == '0) begin
            src_b = '0;
        end else if (e_valid && e_rd == in_rs2) begin
            src_b = alu_y;
        end else if (w_valid && res_rd == in_rs2) begin
            src_b = res_data;
        end

        opnd_b = in_imm_en ? in_imm : src_b;
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0;
            e_rd    <= '0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (e_adv) begin
            e_valid <= in_valid;
            if (in_valid) begin
                e_rd   <= in_rd;
                alu_op <= in_op;
                alu_a  <= src_a;
                alu_b  <= opnd_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid  <= 1'b0;
            res_rd   <= '0;
            res_data <= '0;
        end else if (w_adv) begin
            w_valid  <= e_valid;
            res_rd   <= e_rd;
            res_data <= alu_y;
        end
    end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue/writeback stage wrapped around the combinational `alu`. It accepts register-form instructions over a valid/ready handshake and reads operands from an internal register file, forwarding in-flight results where needed. It presents registered operands and opcode to the ALU, captures the ALU result one cycle later, and retires it downstream over a second valid/ready handshake while writing it back to the register file.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- NREGS, 8, architectural registers; power of two, ≥2; r0 reads zero
- OP_W, 4, opcode width, matches `alu`

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_op  in  OP_W  ALU opcode
- in_rd, in_rs1, in_rs2  in  RW=$clog2(NREGS)  destination/source register indices
- in_imm_en  in  1  1: operand B = in_imm instead of rs2
- in_imm  in  DATA_W  immediate
- alu_op  out  OP_W  registered opcode to ALU
- alu_a, alu_b  out  DATA_W  registered operands to ALU
- alu_y  in  DATA_W  combinational ALU result for alu_op/alu_a/alu_b
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_rd  out  RW  destination of result
- res_data  out  DATA_W  result value

## Operation
- Two pipeline registers:
  - E holds e_valid, alu_op, alu_a, alu_b, e_rd.
  - W holds w_valid, res_rd, res_data.
- res_valid = w_valid.
- Advance rules:
  - w_adv = !w_valid || res_ready.
  - e_adv = !e_valid || w_adv.
  - in_ready = e_adv (combinational, no dependence on in_valid).
- On input handshake, E loads op, rd, and operands A=src(rs1) and B = in_imm_en ? in_imm : src(rs2).
- src(r) priority:
  - r==0 → 0.
  - Else e_valid && e_rd==r → alu_y.
  - Else w_valid && res_rd==r → res_data.
  - Else regfile[r].
- When e_adv && !in_valid: e_valid clears; operand registers hold their values.
- When w_adv: W loads e_valid, e_rd, alu_y.
- Register file write happens only on result handshake (res_valid && res_ready) at res_rd. Writes to r0 are discarded.
- Result order equals acceptance order; no reordering, no dropping while rst_n is high.
- Arithmetic is wholly inside `alu`; this block does no width extension. Immediates are full DATA_W as given.

## Timing
- Reset (async assert, sync deassert at the system level): e_valid=0, w_valid=0, alu_op/alu_a/alu_b/res_rd/res_data=0, all registers=0. in_ready=1 during and after reset.
- Latency with no backpressure:
  - Accept at edge N.
  - alu_* valid after edge N.
  - res_valid high after edge N+1.
  - Register write at the handshake edge.
- Throughput is 1 instruction/cycle while res_ready=1.
- Backpressure:
  - res_ready=0 with W full and E full → in_ready=0 in the same cycle.
  - E and W hold their contents and alu_* stay stable.
- Back-to-back dependency (rd of N = rs of N+1) forwards from E with no bubble. A dependency two deep forwards from W, including when W retires in the same cycle.
- res_valid, once asserted, stays high with res_rd/res_data stable until the handshake.
- Reset mid-operation discards E and W contents; no partial writeback.

## Structure
- Package `alu_pkg`:
  - Opcode enum `alu_op_e`, shared with `alu`.
  - Constants DATA_W_DEF, NREGS_DEF.
  - Typedef `alu_instr_t` {op, rd, rs1, rs2, imm_en, imm}.
- Sub-module `alu_regfile`:
  - NREGS×DATA_W.
  - Two asynchronous read ports, one synchronous write port.
  - r0 hardwired zero; no internal bypass.
  - Async active-low reset clears all entries.
- Forwarding mux and handshake logic live in `alu_dispatch`.

## Test plan
- Reset, then ADD rd=1, imm_en=1, imm=5, rs1=0 → alu_a=0, alu_b=5 one cycle later; res_valid with res_rd=1, res_data=5 two cycles after accept; regfile[1]=5 after handshake.
- Back-to-back: ADD r1=r0+7 (imm), then ADD r2=r1+r1 on the next cycle, res_ready=1 → r2 result 14 with no bubble (E forwarding).
- Dependency two deep: r1=3, nop-free unrelated op r3=r0+1, then r4=r1+r1 → res_data=6 (W forwarding).
- Backpressure: hold res_ready=0 for 4 cycles with 3 instructions offered → in_ready drops after E and W fill; res_rd/res_data stable; after release, results retire in order with correct values.
- Write to r0: ADD r0=r0+9, then ADD r5=r0+0 → res_data=0 for r5; the r0 result is still presented (res_rd=0, 9) but not stored.
- Reset asserted while E and W are full → res_valid=0 and in_ready=1 immediately; registers read 0 afterward; no write from the dropped ops.
